// File: rtl/mctrl_pkg.sv
// ============================================================================
// Module      : mctrl_pkg
// Description : Shared state codes, opcodes and mux/ALU encodings for the
//               multicycle RISC-V controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_JAL      = 4'd10,
        S_BEQ      = 4'd11,
        S_ILLEGAL  = 4'd12
    } state_t;

    localparam logic [6:0] C_OP_LW    = 7'b0000011;
    localparam logic [6:0] C_OP_SW    = 7'b0100011;
    localparam logic [6:0] C_OP_RTYPE = 7'b0110011;
    localparam logic [6:0] C_OP_ITYPE = 7'b0010011;
    localparam logic [6:0] C_OP_JAL   = 7'b1101111;
    localparam logic [6:0] C_OP_BEQ   = 7'b1100011;

    localparam logic [2:0] C_ALU_ADD = 3'b000;
    localparam logic [2:0] C_ALU_SUB = 3'b001;
    localparam logic [2:0] C_ALU_AND = 3'b010;
    localparam logic [2:0] C_ALU_OR  = 3'b011;
    localparam logic [2:0] C_ALU_SLT = 3'b101;

    localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] C_ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] C_IMM_I = 2'b00;
    localparam logic [1:0] C_IMM_S = 2'b01;
    localparam logic [1:0] C_IMM_B = 2'b10;
    localparam logic [1:0] C_IMM_J = 2'b11;

    localparam logic [1:0] C_SRCA_PC    = 2'b00;
    localparam logic [1:0] C_SRCA_OLDPC = 2'b01;
    localparam logic [1:0] C_SRCA_REG   = 2'b10;

    localparam logic [1:0] C_SRCB_REG  = 2'b00;
    localparam logic [1:0] C_SRCB_IMM  = 2'b01;
    localparam logic [1:0] C_SRCB_FOUR = 2'b10;

    localparam logic [1:0] C_RES_ALUOUT    = 2'b00;
    localparam logic [1:0] C_RES_DATA      = 2'b01;
    localparam logic [1:0] C_RES_ALURESULT = 2'b10;

    // Immediate format depends only on the opcode, never on the state.
    function automatic logic [1:0] immsrc_of(input logic [6:0] op);
        case (op)
            C_OP_SW:  immsrc_of = C_IMM_S;
            C_OP_BEQ: immsrc_of = C_IMM_B;
            C_OP_JAL: immsrc_of = C_IMM_J;
            default:  immsrc_of = C_IMM_I;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mctrl_aludec.sv
// ============================================================================
// Module      : mctrl_aludec
// Description : Combinational ALU decoder: aluop/funct3/funct7b5/op[5] to
//               alucontrol.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mctrl_aludec
    import mctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = C_ALU_ADD;
        case (aluop)
            C_ALUOP_SUB: alucontrol = C_ALU_SUB;
            C_ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type (op[5]=1) may select sub; addi ignores funct7b5.
                    3'b000:  alucontrol = (op5 & funct7b5) ? C_ALU_SUB : C_ALU_ADD;
                    3'b010:  alucontrol = C_ALU_SLT;
                    3'b110:  alucontrol = C_ALU_OR;
                    3'b111:  alucontrol = C_ALU_AND;
                    default: alucontrol = C_ALU_ADD;
                endcase
            end
            default: alucontrol = C_ALU_ADD;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multicycle RISC-V control FSM with Moore-decoded datapath
//               strobes. Optional MCTRL_ILLEGAL_EN traps unsupported opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
    import mctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic [1:0] immsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic       adrsrc,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic [2:0] alucontrol,
    output logic       retire,
    output logic [3:0] state
`ifdef MCTRL_ILLEGAL_EN
    ,
    output logic       illegal
`endif
);

    state_t     state_q, state_d;
    logic [1:0] w_aluop;
    logic       w_pcupdate;
    logic       w_branch;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        alusrca    = C_SRCA_PC;
        alusrcb    = C_SRCB_REG;
        resultsrc  = C_RES_ALUOUT;
        adrsrc     = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        memwrite   = 1'b0;
        retire     = 1'b0;
        w_aluop    = C_ALUOP_ADD;
        w_pcupdate = 1'b0;
        w_branch   = 1'b0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                irwrite    = 1'b1;
                w_pcupdate = 1'b1;
                alusrcb    = C_SRCB_FOUR;
                resultsrc  = C_RES_ALURESULT;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                alusrca = C_SRCA_OLDPC;
                alusrcb = C_SRCB_IMM;
                case (op)
                    C_OP_LW, C_OP_SW: state_d = S_MEMADR;
                    C_OP_RTYPE:       state_d = S_EXECR;
                    C_OP_ITYPE:       state_d = S_EXECI;
                    C_OP_JAL:         state_d = S_JAL;
                    C_OP_BEQ:         state_d = S_BEQ;
`ifdef MCTRL_ILLEGAL_EN
                    default:          state_d = S_ILLEGAL;
`else
                    default:          state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alusrca = C_SRCA_REG;
                alusrcb = C_SRCB_IMM;
                state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adrsrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                resultsrc = C_RES_DATA;
                regwrite  = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                adrsrc   = 1'b1;
                memwrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_EXECR: begin
                alusrca = C_SRCA_REG;
                w_aluop = C_ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                alusrca = C_SRCA_REG;
                alusrcb = C_SRCB_IMM;
                w_aluop = C_ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                alusrca    = C_SRCA_OLDPC;
                alusrcb    = C_SRCB_FOUR;
                w_pcupdate = 1'b1;
                state_d    = S_ALUWB;
            end
            S_BEQ: begin
                alusrca  = C_SRCA_REG;
                w_aluop  = C_ALUOP_SUB;
                w_branch = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_ILLEGAL: state_d = S_ILLEGAL;
            default:   state_d = S_RESET;
        endcase
    end

    // Branch decision uses the live zero flag within the BEQ cycle.
    assign pcwrite = w_pcupdate | (w_branch & zero);
    assign immsrc  = immsrc_of(op);
    assign state   = state_q;

    mctrl_aludec u_aludec (
        .aluop      (w_aluop),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .op5        (op[5]),
        .alucontrol (alucontrol)
    );

`ifdef MCTRL_ILLEGAL_EN
    logic illegal_q, illegal_d;

    always_comb begin
        illegal_d = illegal_q | (state_d == S_ILLEGAL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Self-checking bench for multicycle_ctrl against a path-queue
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic [1:0] immsrc, alusrca, alusrcb, resultsrc;
    logic       adrsrc, irwrite, pcwrite, regwrite, memwrite, retire;
    logic [2:0] alucontrol;
    logic [3:0] state;
`ifdef MCTRL_ILLEGAL_EN
    logic       illegal;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic chk_en = 1'b0;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .immsrc     (immsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .resultsrc  (resultsrc),
        .adrsrc     (adrsrc),
        .irwrite    (irwrite),
        .pcwrite    (pcwrite),
        .regwrite   (regwrite),
        .memwrite   (memwrite),
        .alucontrol (alucontrol),
        .retire     (retire),
        .state      (state)
`ifdef MCTRL_ILLEGAL_EN
        ,
        .illegal    (illegal)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: each opcode maps to the list of states it visits after DECODE.
    int exp_state;
    int path[$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_state = 0;
            path.delete();
        end else if (exp_state == 0) begin
            exp_state = 1;
        end else if (exp_state == 1) begin
            exp_state = 2;
        end else if (exp_state == 2) begin
            case (op)
                7'b0000011: path = '{3, 4, 5};
                7'b0100011: path = '{3, 6};
                7'b0110011: path = '{7, 9};
                7'b0010011: path = '{8, 9};
                7'b1101111: path = '{10, 9};
                7'b1100011: path = '{11};
                default:    path.delete();
            endcase
            if (path.size() > 0) exp_state = path.pop_front();
`ifdef MCTRL_ILLEGAL_EN
            else exp_state = 12;
`else
            else exp_state = 1;
`endif
        end else if (exp_state == 12) begin
            exp_state = 12;
        end else if (path.size() > 0) begin
            exp_state = path.pop_front();
        end else begin
            exp_state = 1;
        end
    end

    // Compare process: derive every output from the model state and live inputs.
    always @(negedge clk) begin
        if (chk_en) begin
            int e_a, e_b, e_res, e_adr, e_ir, e_reg, e_mem, e_ret, e_pcu, e_br, e_alu, e_imm;
            e_a = 0; e_b = 0; e_res = 0; e_adr = 0; e_ir = 0; e_reg = 0;
            e_mem = 0; e_ret = 0; e_pcu = 0; e_br = 0; e_alu = 0;
            case (exp_state)
                1:  begin e_ir = 1; e_pcu = 1; e_b = 2; e_res = 2; end
                2:  begin e_a = 1; e_b = 1; end
                3:  begin e_a = 2; e_b = 1; end
                4:  e_adr = 1;
                5:  begin e_res = 1; e_reg = 1; e_ret = 1; end
                6:  begin e_adr = 1; e_mem = 1; e_ret = 1; end
                7:  e_a = 2;
                8:  begin e_a = 2; e_b = 1; end
                9:  begin e_reg = 1; e_ret = 1; end
                10: begin e_a = 1; e_b = 2; e_pcu = 1; end
                11: begin e_a = 2; e_br = 1; e_ret = 1; e_alu = 1; end
                default: ;
            endcase
            if (exp_state == 7 || exp_state == 8) begin
                case (funct3)
                    3'b000:  e_alu = (op[5] && funct7b5) ? 1 : 0;
                    3'b010:  e_alu = 5;
                    3'b110:  e_alu = 3;
                    3'b111:  e_alu = 2;
                    default: e_alu = 0;
                endcase
            end
            case (op)
                7'b0100011: e_imm = 1;
                7'b1100011: e_imm = 2;
                7'b1101111: e_imm = 3;
                default:    e_imm = 0;
            endcase
            check("state",      int'(state),      exp_state);
            check("immsrc",     int'(immsrc),     e_imm);
            check("alusrca",    int'(alusrca),    e_a);
            check("alusrcb",    int'(alusrcb),    e_b);
            check("resultsrc",  int'(resultsrc),  e_res);
            check("adrsrc",     int'(adrsrc),     e_adr);
            check("irwrite",    int'(irwrite),    e_ir);
            check("regwrite",   int'(regwrite),   e_reg);
            check("memwrite",   int'(memwrite),   e_mem);
            check("retire",     int'(retire),     e_ret);
            check("alucontrol", int'(alucontrol), e_alu);
            check("pcwrite",    int'(pcwrite),    (e_pcu == 1 || (e_br == 1 && zero)) ? 1 : 0);
`ifdef MCTRL_ILLEGAL_EN
            check("illegal",    int'(illegal),    (exp_state == 12) ? 1 : 0);
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    logic [6:0] ops [6];

    initial begin
        int lw_seq [6];
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
        ops[3] = 7'b0010011; ops[4] = 7'b1101111; ops[5] = 7'b1100011;
        lw_seq = '{1, 2, 3, 4, 5, 1};
        reset_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
        chk_en = 1'b1;
        tick();
        tick();
        check("reset_state",   int'(state),   0);
        check("reset_irwrite", int'(irwrite), 0);
        check("reset_pcwrite", int'(pcwrite), 0);

        // lw: states 1,2,3,4,5,1 with retire only in MEMWB
        op = 7'b0000011;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("lw_state",  int'(state),  lw_seq[i]);
            check("lw_retire", int'(retire), (i == 4) ? 1 : 0);
            if (i == 4) begin
                check("lw_regwrite",  int'(regwrite),  1);
                check("lw_resultsrc", int'(resultsrc), 1);
            end
        end
        check("lw_immsrc", int'(immsrc), 0);

        // beq taken then not taken
        op = 7'b1100011; zero = 1'b1;
        tick(); tick();
        check("beq_state",    int'(state),   11);
        check("beq_pcwrite1", int'(pcwrite), 1);
        check("beq_immsrc",   int'(immsrc),  2);
        tick();
        zero = 1'b0;
        tick(); tick();
        check("beq_pcwrite0", int'(pcwrite), 0);
        tick();

        // R-type sub and I-type add with funct7b5 set
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
        tick(); tick();
        check("execr_state", int'(state),      7);
        check("execr_sub",   int'(alucontrol), 1);
        tick(); tick();
        op = 7'b0010011;
        tick(); tick();
        check("execi_state", int'(state),      8);
        check("execi_add",   int'(alucontrol), 0);
        tick(); tick();

        // jal
        op = 7'b1101111;
        tick();
        check("jal_immsrc",  int'(immsrc),  3);
        tick();
        check("jal_pcwrite", int'(pcwrite), 1);
        tick();
        check("jal_aluwb_regwrite", int'(regwrite), 1);
        tick();
        check("jal_back_fetch", int'(state), 1);

        // unsupported opcode
        op = 7'b0000000;
        tick();
        check("bad_decode_retire", int'(retire), 0);
        tick();
`ifdef MCTRL_ILLEGAL_EN
        check("bad_state",   int'(state),   12);
        check("bad_illegal", int'(illegal), 1);
        tick(); tick();
        check("bad_stuck",   int'(state),   12);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
`else
        check("bad_skip_fetch", int'(state),  1);
        check("bad_skip_retire", int'(retire), 0);
`endif

        // randomized instruction stream
        for (int k = 0; k < 200; k++) begin
            int guard;
            int sel;
`ifdef MCTRL_ILLEGAL_EN
            sel = int'($urandom_range(0, 5));
`else
            sel = int'($urandom_range(0, 6));
`endif
            op = (sel == 6) ? 7'($urandom) : ops[sel];
            guard = 0;
            do begin
                tick();
                zero = 1'($urandom);
                funct3 = 3'($urandom);
                funct7b5 = 1'($urandom);
                guard++;
            end while (exp_state != 1 && guard < 10);
            if (exp_state != 1) begin
                check("instr_bound", exp_state, 1);
                break;
            end
        end

        // reset asserted mid-MEMREAD
        op = 7'b0000011;
        tick(); tick(); tick();
        check("pre_reset_memread", int'(state), 4);
        reset_n = 1'b0;
        #1;
        check("async_state",  int'(state),  0);
        check("async_adrsrc", int'(adrsrc), 0);
        check("async_strobes", int'({irwrite, pcwrite, regwrite, memwrite, retire}), 0);
        tick();
        reset_n = 1'b1;
        tick();
        check("post_release_fetch", int'(state), 1);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle RISC-V control unit for the clocked simulator core. It sequences each instruction through the Fetch/Decode/Execute/Writeback states and drives every datapath strobe and mux select. It also decodes the opcode into `immsrc`, which selects the immediate format in the immediate-extension unit directly downstream. Supported subset: `lw`, `sw`, R-type (add/sub/and/or/slt), I-type ALU, `beq`, `jal`.

## Interface
- No parameters.
- `clk`  in  1  core clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `op`  in  7  instr[6:0] from the instruction register.
- `funct3`  in  3  instr[14:12].
- `funct7b5`  in  1  instr[30].
- `zero`  in  1  ALU zero flag.
- `immsrc`  out  2  immediate format to the extend unit: 00 I, 01 S, 10 B, 11 J.
- `alusrca`  out  2  ALU A source: 00 PC, 01 OldPC, 10 register A.
- `alusrcb`  out  2  ALU B source: 00 register B, 01 ImmExt, 10 constant 4.
- `resultsrc`  out  2  result source: 00 ALUOut, 01 Data, 10 ALUResult.
- `adrsrc`  out  1  memory address source: 0 PC, 1 Result.
- `irwrite`, `pcwrite`, `regwrite`, `memwrite`  out  1 each  write enables.
- `alucontrol`  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `retire`  out  1  one-cycle pulse in the last cycle of each instruction.
- `state`  out  4  current state code, for the simulator trace.
- `illegal`  out  1  sticky illegal-opcode flag. Present only with `MCTRL_ILLEGAL_EN`.

## Operation
- States and codes:
  - RESET=0, FETCH=1, DECODE=2, MEMADR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6.
  - EXECR=7, EXECI=8, ALUWB=9, JAL=10, BEQ=11, ILLEGAL=12.
- Transitions:
  - RESET→FETCH.
  - FETCH→DECODE.
  - DECODE, by `op`:
    - 0000011 or 0100011 → MEMADR.
    - 0110011 → EXECR.
    - 0010011 → EXECI.
    - 1101111 → JAL.
    - 1100011 → BEQ.
    - Anything else: see Configuration.
  - MEMADR→MEMREAD if `op[5]`=0, otherwise MEMWRITE.
  - MEMREAD→MEMWB→FETCH.
  - MEMWRITE→FETCH.
  - EXECR and EXECI → ALUWB → FETCH.
  - JAL→ALUWB.
  - BEQ→FETCH.
- Outputs are Moore-decoded from `state`. Any strobe not listed for a state is 0, and any select not listed is 00.
  - FETCH: irwrite=1, pcupdate=1, alusrcb=10, resultsrc=10, aluop=00.
  - DECODE: alusrca=01, alusrcb=01, aluop=00 (computes the branch target).
  - MEMADR: alusrca=10, alusrcb=01, aluop=00.
  - MEMREAD: adrsrc=1.
  - MEMWB: resultsrc=01, regwrite=1.
  - MEMWRITE: adrsrc=1, memwrite=1.
  - EXECR: alusrca=10, aluop=10.
  - EXECI: alusrca=10, alusrcb=01, aluop=10.
  - ALUWB: regwrite=1.
  - JAL: alusrca=01, alusrcb=10, pcupdate=1.
  - BEQ: alusrca=10, aluop=01, branch=1.
- `pcwrite = pcupdate | (branch & zero)`.
- ALU decode (`alucontrol`):
  - aluop=00 → add.
  - aluop=01 → sub.
  - aluop=10, by `funct3`:
    - 000 → sub if `op[5] & funct7b5`, otherwise add.
    - 010 → slt.
    - 110 → or.
    - 111 → and.
    - Any other value → add.
- `immsrc` is a pure combinational function of `op`, independent of state:
  - lw and I-type → 00.
  - sw → 01.
  - beq → 10.
  - jal → 11.
  - Anything else → 00.
- `retire`=1 in MEMWB, MEMWRITE, ALUWB and BEQ. It is 0 in every other state.

## Timing
- Reset: asserting `reset_n` low forces `state`=RESET immediately, at any point including mid-instruction.
  - In RESET every strobe is 0, every select is 00, `alucontrol`=000 and `retire`=0.
  - `immsrc` still follows `op`.
- The first rising edge with `reset_n` high moves RESET→FETCH.
- Instruction latency, in cycles: lw 5, sw 4, R/I-type 4, jal 4, beq 3.
- `zero` is sampled combinationally in BEQ only; the `pcwrite` caused by a branch is the same cycle.
- No handshake; the controller assumes single-cycle memory.

## Configuration
- `MCTRL_ILLEGAL_EN` defined:
  - DECODE with an unsupported `op` → ILLEGAL.
  - ILLEGAL holds until reset, with all strobes 0 and `retire`=0.
  - `illegal` is 0 from reset and set to 1 on entry to ILLEGAL.
- `MCTRL_ILLEGAL_EN` undefined:
  - DECODE with an unsupported `op` → FETCH, with `retire`=0 (the instruction is skipped).
  - There is no `illegal` port and no ILLEGAL state.

## Structure
- Shared package `mctrl_pkg` holds:
  - the state enum and its codes;
  - the opcode constants;
  - the `alucontrol`, `immsrc`, `alusrca`/`alusrcb` and `resultsrc` encodings.
- One sub-module, `mctrl_aludec`: combinational `aluop`/`funct3`/`funct7b5`/`op[5]` → `alucontrol`.

## Test plan
- Reset, release, then `op`=0000011: states 1,2,3,4,5,1; `retire` only in state 5; `regwrite`=1 with `resultsrc`=01 in state 5; `immsrc`=00.
- `op`=1100011, `zero`=1: `pcwrite`=1 in BEQ and `immsrc`=10. Repeat with `zero`=0: `pcwrite`=0 in BEQ.
- `op`=0110011, `funct3`=000, `funct7b5`=1 gives `alucontrol`=001 in EXECR. `op`=0010011, `funct3`=000, `funct7b5`=1 gives 000 in EXECI.
- `op`=1101111: `immsrc`=11; JAL asserts `pcwrite`=1; next cycle ALUWB asserts `regwrite`=1.
- `op`=0000000:
  - with the macro: ILLEGAL, `illegal`=1, stuck until reset;
  - without the macro: returns to FETCH after DECODE with no `retire`.
- `reset_n` pulsed low during MEMREAD: `state`=0 and all strobes 0 within the same cycle; FETCH one edge after release.
